// File: rtl/rv32i_mem_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_mem_pkg: shared state encodings, bus widths and byte-lane patterns
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rv32i_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  localparam logic [SEL_W-1:0] SEL_WORD    = 4'b1111;
  localparam logic [SEL_W-1:0] SEL_HALF_LO = 4'b0011;
  localparam logic [SEL_W-1:0] SEL_HALF_HI = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Word accesses need a word-aligned address, halfword accesses an even one.
  function automatic logic sel_misaligned(input logic [SEL_W-1:0] sel,
                                          input logic [1:0]       addr_lo);
    return ((sel == SEL_WORD) && (addr_lo != 2'b00)) ||
           (((sel == SEL_HALF_LO) || (sel == SEL_HALF_HI)) && addr_lo[0]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv32i_dmem_responder_if.sv
// ----------------------------------------------------------------------------
// rv32i_dmem_responder_if: core-to-data-memory request/acknowledge bus
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface rv32i_dmem_responder_if;
  import rv32i_mem_pkg::*;

  logic              req_stb;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [SEL_W-1:0]  req_sel;
  logic              req_ack;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              busy;

  modport master (
    output req_stb, req_we, req_addr, req_wdata, req_sel,
    input  req_ack, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_stb, req_we, req_addr, req_wdata, req_sel,
    output req_ack, resp_rdata, resp_err, busy
  );

endinterface

`default_nettype wire

// File: rtl/rv32i_dmem_responder_array.sv
// ----------------------------------------------------------------------------
// rv32i_dmem_array: synchronous single-port byte-lane RAM with registered read
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rv32i_dmem_array
  import rv32i_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              we_i,
  input  logic              clr_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rdata_q;

  for (genvar l = 0; l < SEL_W; l++) begin : g_lane
    logic [7:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (en_i && we_i && sel_i[l]) begin
        mem_q[idx_i] <= wdata_i[8*l +: 8];
      end
    end

    assign rd_word[8*l +: 8] = mem_q[idx_i];
  end

  // Read register only moves on loads or rejected accesses; stores leave it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (en_i && clr_i) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= rd_word;
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/rv32i_dmem_responder.sv
// ----------------------------------------------------------------------------
// rv32i_dmem_responder: data-port responder with wait states; optional
// address checking via RV32I_DMEM_ADDR_CHECK_EN.  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rv32i_dmem_responder
  import rv32i_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rv32i_dmem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SEL_W-1:0]  sel_q;
  logic              ack_q;
  logic              err_q;
  logic              busy_q;

  logic              take;
  logic              enter_ack;
  logic              we_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] wdata_s;
  logic [SEL_W-1:0]  sel_s;
  logic [ADDR_W-1:0] offset;
  logic              addr_err;
  logic              unused_bits;

  assign take      = (state_q == IDLE) && bus.req_stb;
  assign enter_ack = (take && (WAIT_STATES == 0)) ||
                     ((state_q == WAIT) && (cnt_q == 4'd0));

  // With zero wait states the access completes on the capture edge itself,
  // so the live bus fields feed the RAM while still in IDLE.
  assign we_s    = (state_q == IDLE) ? bus.req_we    : we_q;
  assign addr_s  = (state_q == IDLE) ? bus.req_addr  : addr_q;
  assign wdata_s = (state_q == IDLE) ? bus.req_wdata : wdata_q;
  assign sel_s   = (state_q == IDLE) ? bus.req_sel   : sel_q;

  assign offset      = addr_s - BASE_ADDR;
  assign unused_bits = ^{offset[ADDR_W-1:IDX_W+2], offset[1:0]};

`ifdef RV32I_DMEM_ADDR_CHECK_EN
  logic [ADDR_W:0] addr_limit;
  assign addr_limit = {1'b0, BASE_ADDR} + ({{(ADDR_W+1-32){1'b0}}, 32'(DEPTH_WORDS)} << 2);
  assign addr_err   = (addr_s < BASE_ADDR) ||
                      ({1'b0, addr_s} >= addr_limit) ||
                      sel_misaligned(sel_s, addr_s[1:0]);
`else
  assign addr_err   = 1'b0;
`endif

  rv32i_dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (enter_ack && rst_n),
    .we_i    (we_s && !addr_err),
    .clr_i   (addr_err),
    .sel_i   (sel_s),
    .idx_i   (offset[IDX_W+1:2]),
    .wdata_i (wdata_s),
    .rdata_o (bus.resp_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (take) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            sel_q   <= bus.req_sel;
            busy_q  <= 1'b1;
            if (WAIT_STATES == 0) begin
              state_q <= ACK;
              ack_q   <= 1'b1;
              err_q   <= addr_err;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
            err_q   <= addr_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ACK: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ack  = ack_q;
  assign bus.resp_err = err_q;
  assign bus.busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_rv32i_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_rv32i_dmem_responder: directed bench over four wait-state configurations
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rv32i_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  stb;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;

  logic [3:0]  ack;
  logic [3:0]  err;
  logic [3:0]  busy;
  logic [31:0] rdata [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rv32i_dmem_responder_if u_if [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_bus
    assign u_if[g].req_stb   = stb[g];
    assign u_if[g].req_we    = we;
    assign u_if[g].req_addr  = addr;
    assign u_if[g].req_wdata = wdata;
    assign u_if[g].req_sel   = sel;
    assign ack[g]            = u_if[g].req_ack;
    assign err[g]            = u_if[g].resp_err;
    assign busy[g]           = u_if[g].busy;
    assign rdata[g]          = u_if[g].resp_rdata;
  end

  // Index 0..3 carry WAIT_STATES 0, 1, 3, 15.
  rv32i_dmem_responder #(.WAIT_STATES(0))  u_dut0 (.clk(clk), .rst_n(rst_n), .bus(u_if[0]));
  rv32i_dmem_responder #(.WAIT_STATES(1))  u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if[1]));
  rv32i_dmem_responder #(.WAIT_STATES(3))  u_dut2 (.clk(clk), .rst_n(rst_n), .bus(u_if[2]));
  rv32i_dmem_responder #(.WAIT_STATES(15)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(u_if[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xact(input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] s,
                      output logic [31:0] rd, output logic e,
                      output int lat, output int bcnt);
    @(negedge clk);
    we = w; addr = a; wdata = wd; sel = s; stb[d] = 1'b1;
    lat = 0; bcnt = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (busy[d]) bcnt++;
    end while (!ack[d] && lat < 40);
    chk("ack_seen", 32'(ack[d]), 32'd1);
    rd = rdata[d];
    e  = err[d];
    stb[d] = 1'b0;
    @(posedge clk); #1;
    chk("ack_one_cycle", 32'(ack[d]), 32'd0);
    chk("busy_after_ack", 32'(busy[d]), 32'd0);
  endtask

  task automatic do_store(input int d, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] s, input logic exp_err, input int exp_lat);
    logic [31:0] rd; logic e; int lat; int bcnt;
    xact(d, 1'b1, a, wd, s, rd, e, lat, bcnt);
    chk("store_err", 32'(e), 32'(exp_err));
    chk("store_lat", 32'(lat), 32'(exp_lat));
  endtask

  task automatic do_load(input int d, input logic [31:0] a, input logic [31:0] exp_rd,
                         input logic exp_err, input int exp_lat);
    logic [31:0] rd; logic e; int lat; int bcnt;
    xact(d, 1'b0, a, 32'h0, 4'b1111, rd, e, lat, bcnt);
    chk("load_data", rd, exp_rd);
    chk("load_err", 32'(e), 32'(exp_err));
    chk("load_lat", 32'(lat), 32'(exp_lat));
    chk("load_busy_span", 32'(bcnt), 32'(exp_lat));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd; logic e; int lat; int bcnt; int t; int seen;

    rst_n = 1'b0; stb = 4'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk("rst_ack",   32'(ack[d]),  32'd0);
      chk("rst_busy",  32'(busy[d]), 32'd0);
      chk("rst_err",   32'(err[d]),  32'd0);
      chk("rst_rdata", rdata[d],     32'd0);
    end
    @(negedge clk); rst_n = 1'b1;

    // Store then load, one wait state
    do_store(1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, 2);
    do_load (1, 32'h10, 32'hDEADBEEF, 1'b0, 2);

    // Partial store, then a no-lane store that must leave RAM and rdata alone
    do_store(1, 32'h20, 32'h11223344, 4'b1111, 1'b0, 2);
    do_store(1, 32'h20, 32'h00AA0000, 4'b0100, 1'b0, 2);
    do_load (1, 32'h20, 32'h11AA3344, 1'b0, 2);
    xact(1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, e, lat, bcnt);
    chk("sel0_rdata_held", rd, 32'h11AA3344);
    do_load (1, 32'h20, 32'h11AA3344, 1'b0, 2);
    do_store(1, 32'h24, 32'hFFFF0000, 4'b1111, 1'b0, 2);
    do_store(1, 32'h24, 32'h00001234, 4'b0011, 1'b0, 2);
    do_load (1, 32'h24, 32'hFFFF1234, 1'b0, 2);

    // Wait-state sweep
    do_store(0, 32'h08, 32'hCAFEF00D, 4'b1111, 1'b0, 1);
    do_load (0, 32'h08, 32'hCAFEF00D, 1'b0, 1);
    do_store(2, 32'h08, 32'hA5A5A5A5, 4'b1111, 1'b0, 4);
    do_load (2, 32'h08, 32'hA5A5A5A5, 1'b0, 4);
    do_store(3, 32'h0C, 32'h5A5A0F0F, 4'b1111, 1'b0, 16);
    do_load (3, 32'h0C, 32'h5A5A0F0F, 1'b0, 16);

    // Back-to-back loads with the address changed during WAIT
    do_store(1, 32'h30, 32'h30303030, 4'b1111, 1'b0, 2);
    do_store(1, 32'h34, 32'h34343434, 4'b1111, 1'b0, 2);
    @(negedge clk);
    we = 1'b0; addr = 32'h30; sel = 4'b1111; stb[1] = 1'b1;
    @(posedge clk); #1;
    addr = 32'h34;
    t = 1;
    do begin @(posedge clk); #1; t++; end while (!ack[1] && t < 40);
    chk("b2b_lat1", 32'(t), 32'd2);
    chk("b2b_data1", rdata[1], 32'h30303030);
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!ack[1] && t < 40);
    chk("b2b_spacing", 32'(t), 32'd3);
    chk("b2b_data2", rdata[1], 32'h34343434);
    stb[1] = 1'b0;
    @(posedge clk); #1;
    chk("b2b_idle", 32'(busy[1]), 32'd0);

    // Reset during WAIT cancels the store
    do_store(2, 32'h40, 32'h0BADF00D, 4'b1111, 1'b0, 4);
    @(negedge clk);
    we = 1'b1; addr = 32'h40; wdata = 32'h12345678; sel = 4'b1111; stb[2] = 1'b1;
    @(posedge clk); #1;
    chk("rstwait_busy", 32'(busy[2]), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; stb[2] = 1'b0;
    @(posedge clk); #1;
    chk("rstwait_busy_clr", 32'(busy[2]), 32'd0);
    chk("rstwait_ack", 32'(ack[2]), 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack[2]) seen++;
    end
    chk("rstwait_no_ack", 32'(seen), 32'd0);
    do_load(2, 32'h40, 32'h0BADF00D, 1'b0, 4);

    // Out-of-range and misaligned accesses
    do_store(1, 32'h000, 32'h11111111, 4'b1111, 1'b0, 2);
`ifdef RV32I_DMEM_ADDR_CHECK_EN
    do_store(1, 32'h1000, 32'h22222222, 4'b1111, 1'b1, 2);
    do_load (1, 32'h000, 32'h11111111, 1'b0, 2);
    do_load (1, 32'h002, 32'h00000000, 1'b1, 2);
`else
    do_store(1, 32'h1000, 32'h22222222, 4'b1111, 1'b0, 2);
    do_load (1, 32'h000, 32'h22222222, 1'b0, 2);
    do_load (1, 32'h002, 32'h22222222, 1'b0, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
